// File: rtl/sp_ram_arbiter.sv
// Arbiter sharing one single-port 32-bit word RAM between an OBI fetch port and an OBI data port.
// Build option: define SP_RAM_ARB_ROUND_ROBIN_EN for round-robin instead of data-first priority.
module sp_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  data_req_i,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        winner_data_reg;
  logic        rsp_valid_reg;
  logic        rsp_data_reg;
  logic        rsp_err_reg;
  logic        rsp_read_reg;

  logic        any_req;
  logic        pick_data;
  logic        gnt_any;
  logic        gnt_data;
  logic        gnt_oor;
  logic        ram_hit;
  logic [31:0] sel_addr;
  logic [31:0] rsp_rdata;

  assign any_req = instr_req_i | data_req_i;

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
  logic last_data_reg;
  // On contention the port that was not granted last wins.
  assign pick_data = data_req_i & (~instr_req_i | ~last_data_reg);
`else
  assign pick_data = data_req_i;
`endif

  // Zero wait states grant straight from IDLE; otherwise the grant comes from the locked winner.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_data = 1'b0;
    if (!rst_i) begin
      if (state_reg == STALL) begin
        gnt_any  = (cnt_reg == 4'd1);
        gnt_data = winner_data_reg;
      end else if (WAIT_STATES == 0) begin
        gnt_any  = any_req;
        gnt_data = pick_data;
      end
    end
  end

  assign sel_addr = gnt_data ? data_addr_i : instr_addr_i;
  assign gnt_oor  = |(sel_addr >> ADDR_WIDTH);
  assign ram_hit  = gnt_any & ~gnt_oor;

  assign instr_gnt_o = gnt_any & ~gnt_data;
  assign data_gnt_o  = gnt_any & gnt_data;

  assign ram_en_o    = ram_hit;
  assign ram_addr_o  = ram_hit ? {sel_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign ram_we_o    = ram_hit & gnt_data & data_we_i;
  assign ram_be_o    = ram_hit ? (gnt_data ? data_be_i : 4'hF) : 4'h0;
  assign ram_wdata_o = (ram_hit & gnt_data) ? data_wdata_i : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      winner_data_reg <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_read_reg    <= 1'b0;
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
      last_data_reg   <= 1'b0;
`endif
    end else begin
      rsp_valid_reg <= gnt_any;
      rsp_data_reg  <= gnt_data;
      rsp_err_reg   <= gnt_any & gnt_oor;
      rsp_read_reg  <= ram_hit & ~(gnt_data & data_we_i);
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
      if (gnt_any) begin
        last_data_reg <= gnt_data;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (WAIT_STATES != 0 && any_req) begin
            winner_data_reg <= pick_data;
            cnt_reg         <= 4'(WAIT_STATES);
            state_reg       <= STALL;
          end
        end
        STALL: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write and error responses return zero data; reset also masks a response already in flight.
  assign rsp_rdata      = rsp_read_reg ? ram_rdata_i : 32'h0;

  assign instr_rvalid_o = ~rst_i & rsp_valid_reg & ~rsp_data_reg;
  assign instr_rdata_o  = instr_rvalid_o ? rsp_rdata : 32'h0;
  assign instr_err_o    = instr_rvalid_o & rsp_err_reg;

  assign data_rvalid_o  = ~rst_i & rsp_valid_reg & rsp_data_reg;
  assign data_rdata_o   = data_rvalid_o ? rsp_rdata : 32'h0;
  assign data_err_o     = data_rvalid_o & rsp_err_reg;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed vectors and a random run on a zero-wait instance,
// plus a stall sequence on a three-wait-state instance.
module tb_sp_ram_arbiter;

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic        B0  = 1'b0;
  localparam logic        B1  = 1'b1;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] W5  = 32'hC0DE0005;
  localparam logic [31:0] W6  = 32'hC0DE0006;
  localparam logic [31:0] W9M = 32'hC0DECCDD;
  localparam logic [31:0] WX  = 32'h12345678;

  localparam logic [8:0] E3_IG  = 9'b0_0000_1000;
  localparam logic [8:0] E3_DG  = 9'b0_1000_0000;
  localparam logic [8:0] E3_IRV = 9'b0_0001_0000;
  localparam logic [8:0] E3_DRV = 9'b1_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i0_req, i0_gnt, i0_rvalid, i0_err, d0_req, d0_we, d0_gnt, d0_rvalid, d0_err;
  logic [31:0] i0_addr, i0_rdata, d0_addr, d0_wdata, d0_rdata, r0_wdata, r0_rdata;
  logic [3:0]  d0_be, r0_be;
  logic        r0_en, r0_we;
  logic [7:0]  r0_addr;

  logic        i3_req, i3_gnt, i3_rvalid, i3_err, d3_req, d3_we, d3_gnt, d3_rvalid, d3_err;
  logic [31:0] i3_addr, i3_rdata, d3_addr, d3_wdata, d3_rdata, r3_wdata, r3_rdata;
  logic [3:0]  d3_be, r3_be;
  logic        r3_en, r3_we;
  logic [7:0]  r3_addr;

  sp_ram_arbiter #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(i0_req), .instr_addr_i(i0_addr), .instr_gnt_o(i0_gnt),
    .instr_rvalid_o(i0_rvalid), .instr_rdata_o(i0_rdata), .instr_err_o(i0_err),
    .data_req_i(d0_req), .data_addr_i(d0_addr), .data_we_i(d0_we), .data_be_i(d0_be),
    .data_wdata_i(d0_wdata), .data_gnt_o(d0_gnt), .data_rvalid_o(d0_rvalid),
    .data_rdata_o(d0_rdata), .data_err_o(d0_err),
    .ram_en_o(r0_en), .ram_addr_o(r0_addr), .ram_we_o(r0_we), .ram_be_o(r0_be),
    .ram_wdata_o(r0_wdata), .ram_rdata_i(r0_rdata)
  );

  sp_ram_arbiter #(.ADDR_WIDTH(8), .WAIT_STATES(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(i3_req), .instr_addr_i(i3_addr), .instr_gnt_o(i3_gnt),
    .instr_rvalid_o(i3_rvalid), .instr_rdata_o(i3_rdata), .instr_err_o(i3_err),
    .data_req_i(d3_req), .data_addr_i(d3_addr), .data_we_i(d3_we), .data_be_i(d3_be),
    .data_wdata_i(d3_wdata), .data_gnt_o(d3_gnt), .data_rvalid_o(d3_rvalid),
    .data_rdata_o(d3_rdata), .data_err_o(d3_err),
    .ram_en_o(r3_en), .ram_addr_o(r3_addr), .ram_we_o(r3_we), .ram_be_o(r3_be),
    .ram_wdata_o(r3_wdata), .ram_rdata_i(r3_rdata)
  );

  function automatic logic [31:0] init_word(int w);
    return (w == 4) ? 32'h12345678 : (32'hC0DE0000 | 32'(w));
  endfunction

  // Behavioural RAMs attached to the two instances (registered read, byte-enabled write).
  logic        ram_ready = 1'b0;
  logic [31:0] ram0 [64];
  logic [31:0] ram3 [64];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int w = 0; w < 64; w++) begin
        ram0[w] <= init_word(w);
        ram3[w] <= init_word(w);
      end
      ram_ready <= 1'b1;
    end else begin
      if (r0_en) begin
        if (r0_we) begin
          for (int b = 0; b < 4; b++)
            if (r0_be[b]) ram0[r0_addr[7:2]][8*b +: 8] <= r0_wdata[8*b +: 8];
        end else begin
          r0_rdata <= ram0[r0_addr[7:2]];
        end
      end
      if (r3_en) begin
        if (r3_we) begin
          for (int b = 0; b < 4; b++)
            if (r3_be[b]) ram3[r3_addr[7:2]][8*b +: 8] <= r3_wdata[8*b +: 8];
        end else begin
          r3_rdata <= ram3[r3_addr[7:2]];
        end
      end
    end
  end

  // OBI rule: a request that was not granted must still be present in the next cycle.
  logic i0_pend = 1'b0, d0_pend = 1'b0, i3_pend = 1'b0, d3_pend = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      i0_pend <= 1'b0; d0_pend <= 1'b0; i3_pend <= 1'b0; d3_pend <= 1'b0;
    end else begin
      if (i0_pend) assert (i0_req) else $error("FAIL obi_hold instr0: req dropped before gnt");
      if (d0_pend) assert (d0_req) else $error("FAIL obi_hold data0: req dropped before gnt");
      if (i3_pend) assert (i3_req) else $error("FAIL obi_hold instr3: req dropped before gnt");
      if (d3_pend) assert (d3_req) else $error("FAIL obi_hold data3: req dropped before gnt");
      i0_pend <= i0_req && !i0_gnt;
      d0_pend <= d0_req && !d0_gnt;
      i3_pend <= i3_req && !i3_gnt;
      d3_pend <= d3_req && !d3_gnt;
    end
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void check_idle(string tag);
    chk({tag, "_ctl0"}, 32'({i0_gnt, i0_rvalid, i0_err, d0_gnt, d0_rvalid, d0_err,
                              r0_en, r0_we, r0_be, r0_addr}), Z);
    chk({tag, "_data0"}, i0_rdata | d0_rdata | r0_wdata, Z);
    chk({tag, "_ctl3"}, 32'({i3_gnt, i3_rvalid, i3_err, d3_gnt, d3_rvalid, d3_err,
                              r3_en, r3_we, r3_be, r3_addr}), Z);
    chk({tag, "_data3"}, i3_rdata | d3_rdata | r3_wdata, Z);
  endfunction

  task automatic drive0(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
    i0_req = ir; i0_addr = ia; d0_req = dr; d0_addr = da;
    d0_we = we; d0_be = be; d0_wdata = wd;
  endtask

  task automatic drive3(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da);
    i3_req = ir; i3_addr = ia; d3_req = dr; d3_addr = da;
    d3_we = 1'b0; d3_be = 4'hF; d3_wdata = Z;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r = $urandom;
    if (r[2:0] == 3'd0) return r | 32'h100;
    return {24'h0, 8'($urandom)};
  endfunction

  typedef struct {
    logic ir; logic [31:0] ia; logic dr; logic [31:0] da; logic we; logic [3:0] be; logic [31:0] wd;
    logic e_ig; logic e_dg; logic e_en; logic [7:0] e_addr; logic e_we; logic [3:0] e_be;
    logic e_irv; logic [31:0] e_ird; logic e_ierr; logic e_drv; logic [31:0] e_drd; logic e_derr;
  } vec_t;

  vec_t vt [12];

  logic        ir, dr, dwe, egi, egd, oor, en, wr, hi, hd, p_iv, p_dv, p_err, m_last_d;
  logic [31:0] ia, da, dwd, ga, p_rd;
  logic [3:0]  dbe;
  logic [31:0] m_mem [64];

  initial begin
    vt[0] = '{B1,32'h14,B1,32'h18,B0,4'hF,Z, B0,B1,B1,8'h18,B0,4'hF, B0,Z,B0, B0,Z,B0};
    if (RR) begin
      vt[1] = '{B1,32'h14,B1,32'h18,B0,4'hF,Z, B1,B0,B1,8'h14,B0,4'hF, B0,Z,B0, B1,W6,B0};
      vt[2] = '{B1,32'h14,B1,32'h18,B0,4'hF,Z, B0,B1,B1,8'h18,B0,4'hF, B1,W5,B0, B0,Z,B0};
      vt[3] = vt[1];
      vt[4] = '{B0,Z,B1,32'h18,B0,4'hF,Z, B0,B1,B1,8'h18,B0,4'hF, B1,W5,B0, B0,Z,B0};
      vt[5] = '{B1,32'h10,B0,Z,B0,4'h0,Z, B1,B0,B1,8'h10,B0,4'hF, B0,Z,B0, B1,W6,B0};
    end else begin
      vt[1] = '{B1,32'h14,B1,32'h18,B0,4'hF,Z, B0,B1,B1,8'h18,B0,4'hF, B0,Z,B0, B1,W6,B0};
      vt[2] = vt[1];
      vt[3] = vt[1];
      vt[4] = '{B1,32'h14,B0,Z,B0,4'h0,Z, B1,B0,B1,8'h14,B0,4'hF, B0,Z,B0, B1,W6,B0};
      vt[5] = '{B1,32'h10,B0,Z,B0,4'h0,Z, B1,B0,B1,8'h10,B0,4'hF, B1,W5,B0, B0,Z,B0};
    end
    vt[6]  = '{B0,Z,B1,32'h24,B1,4'h3,32'hAABBCCDD, B0,B1,B1,8'h24,B1,4'h3, B1,WX,B0, B0,Z,B0};
    vt[7]  = '{B0,Z,B1,32'h24,B0,4'hF,Z, B0,B1,B1,8'h24,B0,4'hF, B0,Z,B0, B1,Z,B0};
    vt[8]  = '{B0,Z,B0,Z,B0,4'h0,Z, B0,B0,B0,8'h0,B0,4'h0, B0,Z,B0, B1,W9M,B0};
    vt[9]  = '{B0,Z,B1,32'h1000,B0,4'hF,Z, B0,B1,B0,8'h0,B0,4'h0, B0,Z,B0, B0,Z,B0};
    vt[10] = '{B1,32'h100,B0,Z,B0,4'h0,Z, B1,B0,B0,8'h0,B0,4'h0, B0,Z,B0, B1,Z,B1};
    vt[11] = '{B0,Z,B0,Z,B0,4'h0,Z, B0,B0,B0,8'h0,B0,4'h0, B1,Z,B1, B0,Z,B0};

    rst = 1'b1;
    drive0(B0, Z, B0, Z, B0, 4'h0, Z);
    drive3(B0, Z, B0, Z);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Directed vectors on the zero-wait instance
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      drive0(vt[k].ir, vt[k].ia, vt[k].dr, vt[k].da, vt[k].we, vt[k].be, vt[k].wd);
      @(negedge clk);
      chk($sformatf("v%0d_igdt", k), 32'(i0_gnt), 32'(vt[k].e_ig));
      chk($sformatf("v%0d_dgnt", k), 32'(d0_gnt), 32'(vt[k].e_dg));
      chk($sformatf("v%0d_ram_en", k), 32'(r0_en), 32'(vt[k].e_en));
      if (vt[k].e_en) begin
        chk($sformatf("v%0d_ram_addr", k), 32'(r0_addr), 32'(vt[k].e_addr));
        chk($sformatf("v%0d_ram_we", k), 32'(r0_we), 32'(vt[k].e_we));
        chk($sformatf("v%0d_ram_be", k), 32'(r0_be), 32'(vt[k].e_be));
        if (vt[k].e_we) chk($sformatf("v%0d_ram_wdata", k), r0_wdata, vt[k].wd);
      end
      chk($sformatf("v%0d_irvalid", k), 32'(i0_rvalid), 32'(vt[k].e_irv));
      if (vt[k].e_irv) begin
        chk($sformatf("v%0d_irdata", k), i0_rdata, vt[k].e_ird);
        chk($sformatf("v%0d_ierr", k), 32'(i0_err), 32'(vt[k].e_ierr));
      end
      chk($sformatf("v%0d_drvalid", k), 32'(d0_rvalid), 32'(vt[k].e_drv));
      if (vt[k].e_drv) begin
        chk($sformatf("v%0d_drdata", k), d0_rdata, vt[k].e_drd);
        chk($sformatf("v%0d_derr", k), 32'(d0_err), 32'(vt[k].e_derr));
      end
    end

    // Three wait states: instr at cycle 0, data joins at cycle 1 and must wait its turn
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      drive3(logic'(c <= 3), 32'h10, logic'(c >= 1 && c <= 7), 32'h24);
      @(negedge clk);
      chk($sformatf("ws3_c%0d_igdt", c), 32'(i3_gnt), 32'(E3_IG[c]));
      chk($sformatf("ws3_c%0d_dgnt", c), 32'(d3_gnt), 32'(E3_DG[c]));
      chk($sformatf("ws3_c%0d_ram_en", c), 32'(r3_en), 32'(E3_IG[c] | E3_DG[c]));
      if (E3_IG[c]) chk($sformatf("ws3_c%0d_ram_addr", c), 32'(r3_addr), 32'h10);
      if (E3_DG[c]) chk($sformatf("ws3_c%0d_ram_addr", c), 32'(r3_addr), 32'h24);
      chk($sformatf("ws3_c%0d_irvalid", c), 32'(i3_rvalid), 32'(E3_IRV[c]));
      chk($sformatf("ws3_c%0d_drvalid", c), 32'(d3_rvalid), 32'(E3_DRV[c]));
      if (E3_IRV[c]) chk($sformatf("ws3_c%0d_irdata", c), i3_rdata, WX);
      if (E3_DRV[c]) chk($sformatf("ws3_c%0d_drdata", c), d3_rdata, 32'hC0DE0009);
    end

    // Reset one cycle after a grant drops the pending response
    @(posedge clk); #1;
    drive0(B1, 32'h10, B0, Z, B0, 4'h0, Z);
    @(negedge clk);
    chk("rstt_gnt", 32'(i0_gnt), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive0(B0, Z, B0, Z, B0, 4'h0, Z);
    @(negedge clk);
    check_idle("rstt_in0");
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("rstt_in1");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("rstt_out0");
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("rstt_out1");

    // Random traffic against a reference model of the arbitration and memory rules
    for (int w = 0; w < 64; w++) m_mem[w] = init_word(w);
    m_mem[9] = W9M;
    m_last_d = 1'b0;
    hi = 1'b0; hd = 1'b0; p_iv = 1'b0; p_dv = 1'b0; p_err = 1'b0; p_rd = Z;
    ir = 1'b0; dr = 1'b0; ia = Z; da = Z; dwe = 1'b0; dbe = 4'h0; dwd = Z;
    for (int n = 0; n < 304; n++) begin
      @(posedge clk); #1;
      if (!hi) begin
        ir = logic'(n < 300 && $urandom_range(9) < 6);
        ia = rand_addr();
      end
      if (!hd) begin
        dr  = logic'(n < 300 && $urandom_range(9) < 6);
        da  = rand_addr();
        dwe = logic'($urandom_range(1));
        dbe = 4'($urandom);
        dwd = $urandom;
      end
      drive0(ir, ia, dr, da, dwe, dbe, dwd);
      egd = dr && (!ir || !RR || !m_last_d);
      egi = ir && !egd;
      ga  = egd ? da : ia;
      oor = (ga >> 8) != 0;
      en  = (egi || egd) && !oor;
      wr  = egd && dwe;
      @(negedge clk);
      chk($sformatf("rnd%0d_igdt", n), 32'(i0_gnt), 32'(egi));
      chk($sformatf("rnd%0d_dgnt", n), 32'(d0_gnt), 32'(egd));
      chk($sformatf("rnd%0d_ram_en", n), 32'(r0_en), 32'(en));
      if (en) begin
        chk($sformatf("rnd%0d_ram_addr", n), 32'(r0_addr), {24'h0, ga[7:2], 2'b00});
        chk($sformatf("rnd%0d_ram_we", n), 32'(r0_we), 32'(wr));
        if (wr) chk($sformatf("rnd%0d_ram_wdata", n), r0_wdata, dwd);
      end
      chk($sformatf("rnd%0d_irvalid", n), 32'(i0_rvalid), 32'(p_iv));
      chk($sformatf("rnd%0d_drvalid", n), 32'(d0_rvalid), 32'(p_dv));
      if (p_iv) begin
        chk($sformatf("rnd%0d_irdata", n), i0_rdata, p_rd);
        chk($sformatf("rnd%0d_ierr", n), 32'(i0_err), 32'(p_err));
      end
      if (p_dv) begin
        chk($sformatf("rnd%0d_drdata", n), d0_rdata, p_rd);
        chk($sformatf("rnd%0d_derr", n), 32'(d0_err), 32'(p_err));
      end
      p_iv  = egi;
      p_dv  = egd;
      p_err = (egi || egd) && oor;
      p_rd  = (en && !wr) ? m_mem[ga[7:2]] : Z;
      if (en && wr)
        for (int b = 0; b < 4; b++)
          if (dbe[b]) m_mem[ga[7:2]][8*b +: 8] = dwd[8*b +: 8];
      if (egi || egd) m_last_d = egd;
      hi = ir && !egi;
      hd = dr && !egd;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Shares one single-port 32-bit word RAM (byte-enabled writes, 1-cycle registered read latency) between the core instruction-fetch port and the data port.
- Both requester sides use an OBI-style req/gnt/rvalid handshake.
- Sits in the core testbench between the core's instr/data interfaces and the RAM instance.
- Performs arbitration, inserts programmable wait states before grant, and generates an error response for out-of-range addresses.

Parameters:
- ADDR_WIDTH, 8, width of the RAM byte-address port; the RAM decodes bits [ADDR_WIDTH-1:2].
- WAIT_STATES, 0, extra cycles between arbitration win and gnt, range 0..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch error, qualified by rvalid
- data_req_i  in  1  data request
- data_addr_i  in  32  data byte address
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error, qualified by rvalid
- ram_en_o  out  1  RAM access strobe
- ram_addr_o  out  ADDR_WIDTH  RAM byte address, bits [1:0] forced to 0
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_en_o

Behaviour:
- Reset: all outputs 0; FSM in IDLE; wait counter 0; response pipeline cleared. A response pending when reset is asserted is dropped, so no rvalid follows reset.
- FSM states:
  - IDLE: if any req is asserted, select a winner.
    - WAIT_STATES==0: assert the winner's gnt combinationally in the same cycle; remain in IDLE.
    - WAIT_STATES>0: latch the winner, load counter = WAIT_STATES, go to STALL. No gnt in that cycle.
  - STALL: decrement the counter each cycle. When the counter reaches 1, assert the locked winner's gnt in the following cycle, then return to IDLE.
  - The winner stays locked during STALL even if the other port raises req.
- Requesters hold req, addr, we, be and wdata stable until gnt (OBI rule). Deasserting req during STALL is illegal; the bench checks this with an assertion.
- Grant cycle, address in range:
  - ram_en_o=1; ram_addr_o = addr[ADDR_WIDTH-1:2],2'b00.
  - ram_we_o, ram_be_o and ram_wdata_o come from the data port; for instr, we=0 and be=4'hF.
- Grant cycle, address out of range (any of addr[31:ADDR_WIDTH] nonzero): gnt is given, ram_en_o=0, and the error flag is registered.
- Response: exactly one cycle after gnt, the owner's rvalid=1.
  - rdata = ram_rdata_i for an in-range read.
  - rdata = 0 for writes and for errors.
  - err = 1 only for out-of-range.
- Never more than one gnt per cycle; gnt only to a port with req=1.
- Throughput with WAIT_STATES==0: one grant per cycle, and a new gnt may coincide with the previous rvalid (back-to-back).
- Throughput with WAIT_STATES=N: one access per N+1 cycles.
- Default arbitration: fixed priority, data over instr, with simultaneous requests resolved in favour of data.
- No requester-side backpressure on rvalid.

Optional Feature:
- Macro: SP_RAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A 1-bit last-grant register, reset to instr, is updated on every gnt. On contention, the port not granted last wins. A lone requester always wins.
- Undefined: fixed data-over-instr priority; no last-grant register is instantiated.

Test Plan:
- WAIT_STATES=0, instr read at 0x10, RAM word 0x12345678 -> instr_gnt same cycle; ram_addr_o=0x10; instr_rvalid next cycle with rdata 0x12345678 and err 0.
- Data write addr 0x24, be=4'b0011, wdata 0xAABBCCDD, then read 0x24 -> ram_we_o=1 with be 0x3 on the write; data_rvalid with rdata 0 on the write; the following read returns the updated bytes with the upper bytes unchanged.
- Both ports request continuously for 4 cycles, fixed priority -> data granted 4×, instr starved. With the macro defined: grants alternate data, instr, data, instr (data first, since last-grant resets to instr).
- WAIT_STATES=3, single instr request -> gnt on cycle 3 after req (cycles 0–2 no gnt); rvalid on cycle 4. A data req raised in cycle 1 gets no gnt before instr's gnt.
- Data read addr 0x0000_1000 with ADDR_WIDTH=8 -> gnt; ram_en_o=0; next cycle data_rvalid=1, data_err=1, rdata=0.
- rst_i asserted in the cycle after a gnt -> no rvalid observed; all outputs 0 during and after reset until a new request.
